// File: rtl/sram_stream_fifo_1024x36_pkg.sv
// Shared constants and types for the SRAM-backed stream FIFO.
package sram_fifo_pkg;
    localparam int unsigned DATA_W    = 36;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned MEM_CAP   = 1023;
    localparam int unsigned PF_DEPTH  = 2;
    localparam int unsigned LEVEL_W   = 11;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/sram_stream_fifo_1024x36_if.sv
// Input and output valid/ready streams of the SRAM stream FIFO.
interface sram_stream_fifo_1024x36_if;
    import sram_fifo_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sram_1024x36.sv
// Behavioural model of the 1024x36 dual-port macro: write every edge, registered read.
module sram_1024x36
    import sram_fifo_pkg::*;
(
    input  logic  clk,
    input  addr_t waddr,
    input  word_t wdata,
    input  addr_t raddr,
    output word_t rdata
);
    word_t mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        mem[waddr] <= wdata;
        rdata      <= mem[raddr];
    end
endmodule

// File: rtl/sram_stream_fifo_1024x36_prefetch2.sv
// Two-entry in-order prefetch buffer fed by SRAM read data; capture and pop may coincide.
module sram_fifo_prefetch2
    import sram_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  word_t      wr_data,
    input  logic       pop,
    output word_t      head,
    output logic [1:0] cnt
);
    word_t      ent_q [PF_DEPTH];
    word_t      ent_d [PF_DEPTH];
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // The caller never writes when full without popping, nor pops when empty.
    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        unique case ({wr_en, pop})
            2'b10: begin
                ent_d[cnt_q[0]] = wr_data;
                cnt_d           = cnt_q + 2'd1;
            end
            2'b01: begin
                ent_d[0] = ent_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent_d[0] = wr_data;
                end else begin
                    ent_d[0] = ent_q[1];
                    ent_d[1] = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign head = ent_q[0];
    assign cnt  = cnt_q;
endmodule

// File: rtl/sram_stream_fifo_1024x36.sv
// Streaming FIFO around one sram_1024x36 macro with a 2-entry prefetch on the read side.
module sram_stream_fifo_1024x36
    import sram_fifo_pkg::*;
#(
    parameter int unsigned AFULL_TH = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_stream_fifo_1024x36_if.slave bus,
    output logic [LEVEL_W-1:0]      level,
    output logic                    almost_full
);
    addr_t             wr_ptr_q, wr_ptr_d;
    addr_t             rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] mem_cnt_q, mem_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        pf_cnt;
    logic [2:0]        pf_budget;
    logic              in_ready, push, pop, issue;
    word_t             rdata, head;

    // Reads are issued only when the prefetch slots, counting the word in flight, can absorb them.
    always_comb begin
        in_ready   = !rst && (mem_cnt_q != ADDR_W'(MEM_CAP));
        push       = bus.in_valid && in_ready;
        pop        = (pf_cnt != 2'd0) && bus.out_ready;
        pf_budget  = {1'b0, pf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (mem_cnt_q != '0) && (pf_budget < 3'd2);
        wr_ptr_d   = wr_ptr_q + addr_t'(push);
        rd_ptr_d   = rd_ptr_q + addr_t'(issue);
        mem_cnt_d  = mem_cnt_q + ADDR_W'(push) - ADDR_W'(issue);
        inflight_d = issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    sram_1024x36 u_sram (
        .clk   (clk),
        .waddr (wr_ptr_q),
        .wdata (bus.in_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    sram_fifo_prefetch2 u_prefetch (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data (rdata),
        .pop     (pop),
        .head    (head),
        .cnt     (pf_cnt)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (pf_cnt != 2'd0);
    assign bus.out_data  = head;
    assign level         = LEVEL_W'(mem_cnt_q) + LEVEL_W'(inflight_q) + LEVEL_W'(pf_cnt);
    assign almost_full   = (level >= LEVEL_W'(AFULL_TH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ({1'b0, pf_cnt} + {2'b00, inflight_q} <= 3'd2);
            assert (mem_cnt_q == ADDR_W'(wr_ptr_q - rd_ptr_q));
        end
    end
endmodule

// File: tb/tb_sram_stream_fifo_1024x36.sv
// Directed and scoreboarded bench for sram_stream_fifo_1024x36.
module tb_sram_stream_fifo_1024x36;
    import sram_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [LEVEL_W-1:0] level;
    logic almost_full;
    int passed = 0;
    int total  = 0;
    word_t sb[$];

    always #5 clk = ~clk;

    sram_stream_fifo_1024x36_if bus();

    sram_stream_fifo_1024x36 #(.AFULL_TH(1000)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .level       (level),
        .almost_full (almost_full)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 36'h123; bus.out_ready = 1'b0;
        repeat (3) step();
        total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); else passed++;
        total++; if (level !== 11'd0) $display("FAIL rst_level got=%0d exp=0", level); else passed++;
        total++; if (almost_full !== 1'b0) $display("FAIL rst_afull got=%0b exp=0", almost_full); else passed++;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_in_ready got=%0b exp=1", bus.in_ready); else passed++;
        sb.delete();
    endtask

    task automatic test_latency();
        total++; if (level !== 11'd0) $display("FAIL lat_level_c0 got=%0d exp=0", level); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL lat_in_ready got=%0b exp=1", bus.in_ready); else passed++;
        bus.in_valid = 1'b1; bus.in_data = 36'h0DEADBEEF; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_out_valid_c%0d got=%0b exp=0", c, bus.out_valid); else passed++;
            total++; if (level !== 11'd1) $display("FAIL lat_level_c%0d got=%0d exp=1", c, level); else passed++;
            step();
        end
        total++; if (bus.out_valid !== 1'b1) $display("FAIL lat_out_valid_c3 got=%0b exp=1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 36'h0DEADBEEF) $display("FAIL lat_out_data got=%h exp=0deadbeef", bus.out_data); else passed++;
        total++; if (level !== 11'd1) $display("FAIL lat_level_c3 got=%0d exp=1", level); else passed++;
        step();
        total++; if (level !== 11'd0) $display("FAIL lat_level_c4 got=%0d exp=0", level); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_out_valid_c4 got=%0b exp=0", bus.out_valid); else passed++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stream();
        int sent = 0, got = 0, cyc = 0, max_level = 0, bubbles = 0;
        logic push, pop;
        while (got < 2000 && cyc < 3000) begin
            if (got > 0 && got < 2000 && !bus.out_valid) bubbles++;
            if (int'(level) > max_level) max_level = int'(level);
            bus.out_ready = 1'b1;
            bus.in_valid  = (sent < 2000);
            bus.in_data   = word_t'(sent);
            push = bus.in_valid && bus.in_ready;
            pop  = bus.out_valid && bus.out_ready;
            if (pop) begin
                total++;
                if (bus.out_data !== word_t'(got)) $display("FAIL stream_data idx=%0d got=%h exp=%h", got, bus.out_data, word_t'(got));
                else passed++;
                got++;
            end
            if (push) sent++;
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++; if (got !== 2000) $display("FAIL stream_count got=%0d exp=2000", got); else passed++;
        total++; if (bubbles !== 0) $display("FAIL stream_bubbles got=%0d exp=0", bubbles); else passed++;
        total++; if (max_level > 3) $display("FAIL stream_max_level got=%0d exp<=3", max_level); else passed++;
        total++; if (level !== 11'd0) $display("FAIL stream_end_level got=%0d exp=0", level); else passed++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        int accepted = 0, low_run = 0, cyc = 0, lvl_err = 0, af_err = 0, got = 0;
        word_t exp_w;
        bus.out_ready = 1'b0;
        while (low_run < 5 && cyc < 1300) begin
            if (int'(level) != accepted) lvl_err++;
            if (almost_full !== (accepted >= 1000)) af_err++;
            bus.in_valid = 1'b1;
            bus.in_data  = 36'h500000000 + word_t'(accepted);
            if (bus.in_ready) begin
                sb.push_back(bus.in_data);
                accepted++;
                low_run = 0;
            end else begin
                low_run++;
            end
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++; if (accepted !== 1025) $display("FAIL fill_accepted got=%0d exp=1025", accepted); else passed++;
        total++; if (level !== 11'd1025) $display("FAIL fill_level got=%0d exp=1025", level); else passed++;
        total++; if (almost_full !== 1'b1) $display("FAIL fill_afull got=%0b exp=1", almost_full); else passed++;
        total++; if (lvl_err !== 0) $display("FAIL fill_level_track got=%0d exp=0 errors", lvl_err); else passed++;
        total++; if (af_err !== 0) $display("FAIL fill_afull_track got=%0d exp=0 errors", af_err); else passed++;
        cyc = 0;
        while (sb.size() > 0 && cyc < 1200) begin
            bus.out_ready = 1'b1;
            if (cyc == 0) begin
                total++; if (bus.in_ready !== 1'b0) $display("FAIL full_pop_in_ready got=%0b exp=0", bus.in_ready); else passed++;
            end
            if (cyc == 1) begin
                total++; if (bus.in_ready !== 1'b1) $display("FAIL full_after_pop_in_ready got=%0b exp=1", bus.in_ready); else passed++;
            end
            if (bus.out_valid) begin
                exp_w = sb.pop_front();
                total++;
                if (bus.out_data !== exp_w) $display("FAIL drain_data idx=%0d got=%h exp=%h", got, bus.out_data, exp_w);
                else passed++;
                got++;
            end
            step();
            cyc++;
        end
        total++; if (got !== 1025) $display("FAIL drain_count got=%0d exp=1025", got); else passed++;
        total++; if (level !== 11'd0) $display("FAIL drain_level got=%0d exp=0", level); else passed++;
        bus.out_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_wrap();
        int sent = 0, got = 0, cyc = 0, lvl_err = 0;
        word_t exp_w;
        logic push, pop;
        for (int r = 0; r < 3; r++) begin
            while (got < (r + 1) * 1100 && cyc < 30000) begin
                if (int'(level) != sent - got) lvl_err++;
                bus.in_valid  = (sent < (r + 1) * 1100) && ($urandom_range(0, 1) == 1);
                bus.in_data   = 36'hA00000000 + word_t'(sent);
                bus.out_ready = ($urandom_range(0, 1) == 1);
                push = bus.in_valid && bus.in_ready;
                pop  = bus.out_valid && bus.out_ready;
                if (pop) begin
                    exp_w = sb.pop_front();
                    total++;
                    if (bus.out_data !== exp_w) $display("FAIL wrap_data idx=%0d got=%h exp=%h", got, bus.out_data, exp_w);
                    else passed++;
                    got++;
                end
                if (push) begin
                    sb.push_back(bus.in_data);
                    sent++;
                end
                step();
                cyc++;
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        total++; if (got !== 3300) $display("FAIL wrap_count got=%0d exp=3300", got); else passed++;
        total++; if (lvl_err !== 0) $display("FAIL wrap_level_track got=%0d exp=0 errors", lvl_err); else passed++;
        sb.delete();
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, cyc = 0;
        logic prev_stall = 1'b0;
        word_t prev_data = '0;
        word_t exp_w;
        logic push, pop;
        while (got < 200 && cyc < 1000) begin
            if (prev_stall) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)
                    $display("FAIL bp_hold cyc=%0d got=%0b/%h exp=1/%h", cyc, bus.out_valid, bus.out_data, prev_data);
                else passed++;
            end
            bus.out_ready = cyc[0];
            bus.in_valid  = (sent < 200);
            bus.in_data   = 36'hB00000000 + word_t'(sent);
            push = bus.in_valid && bus.in_ready;
            pop  = bus.out_valid && bus.out_ready;
            if (pop) begin
                exp_w = sb.pop_front();
                total++;
                if (bus.out_data !== exp_w) $display("FAIL bp_data idx=%0d got=%h exp=%h", got, bus.out_data, exp_w);
                else passed++;
                got++;
            end
            if (push) begin
                sb.push_back(bus.in_data);
                sent++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            step();
            cyc++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        total++; if (got !== 200) $display("FAIL bp_count got=%0d exp=200", got); else passed++;
        sb.delete();
    endtask

    task automatic test_reset_midstream();
        int sent = 0, cyc = 0, stale = 0;
        bit seen = 1'b0;
        bus.out_ready = 1'b0;
        while (sent < 500 && cyc < 700) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 36'hC00000000 + word_t'(sent);
            if (bus.in_ready) sent++;
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++; if (level !== 11'd500) $display("FAIL mid_level_before got=%0d exp=500", level); else passed++;
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 36'hFFF;
        step();
        total++; if (bus.in_ready !== 1'b0) $display("FAIL mid_rst_in_ready got=%0b exp=0", bus.in_ready); else passed++;
        rst = 1'b0; bus.in_valid = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid got=%0b exp=0", bus.out_valid); else passed++;
        total++; if (level !== 11'd0) $display("FAIL mid_level got=%0d exp=0", level); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_in_ready got=%0b exp=1", bus.in_ready); else passed++;
        bus.in_valid = 1'b1; bus.in_data = 36'h1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                total++; if (bus.out_data !== 36'h1) $display("FAIL mid_first_word got=%h exp=000000001", bus.out_data); else passed++;
            end
            step();
        end
        total++; if (!seen) $display("FAIL mid_word_timeout got=0 exp=1 out_valid within 10 cycles"); else passed++;
        for (int c = 0; c < 5; c++) begin
            if (bus.out_valid) stale++;
            step();
        end
        total++; if (stale !== 0) $display("FAIL mid_stale got=%0d exp=0 extra words", stale); else passed++;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_stream();
        test_fill_drain();
        test_wrap();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
